// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: forward/inverse S-box tables and
// the sequencer state encoding used by aes_sbox_seq.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } sbox_state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte of S-box substitution, purely combinational table lookup.
// With INV_EN=0 the select folds to constant 0 and the inverse table is pruned.
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  localparam logic INV_ON = (INV_EN != 0);

  logic use_inv;

  assign use_inv = inv & INV_ON;

  always_comb begin
    dout = SBOX_FWD[din];
    if (use_inv) begin
      dout = SBOX_INV[din];
    end
  end

endmodule

// File: rtl/aes_sbox_seq.sv
// Sequential AES SubBytes/InvSubBytes: substitutes a 128-bit state word
// SBOX_LANES bytes per cycle, then holds the result until it is taken.
module aes_sbox_seq
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4,
  parameter int INV_EN     = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv_mode,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int PASSES = 16 / SBOX_LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int GW     = 8 * SBOX_LANES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASSES - 1);
  localparam logic INV_ON = (INV_EN != 0);

  sbox_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [127:0]     data_reg, data_next;
  logic [127:0]     data_sub;
  logic             mode_reg, mode_next;
  logic [GW-1:0]    grp_in;
  logic [GW-1:0]    grp_out;

  // A single GW-wide group is selected by cnt and written back in place.
  generate
    if (PASSES == 1) begin : g_one
      assign grp_in   = data_reg;
      assign data_sub = grp_out;
    end else begin : g_multi
      logic [GW-1:0] groups [PASSES];
      for (genvar gi = 0; gi < PASSES; gi++) begin : g_grp
        assign groups[gi] = data_reg[gi*GW +: GW];
        assign data_sub[gi*GW +: GW] = (cnt_reg == CNT_W'(gi)) ? grp_out
                                                               : data_reg[gi*GW +: GW];
      end
      assign grp_in = groups[cnt_reg];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < SBOX_LANES; gi++) begin : g_lane
      aes_sbox_lane #(
        .INV_EN (INV_EN)
      ) u_lane (
        .din  (grp_in[gi*8 +: 8]),
        .inv  (mode_reg),
        .dout (grp_out[gi*8 +: 8])
      );
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    mode_next  = mode_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_next  = data_in;
          mode_next  = inv_mode & INV_ON;
          cnt_next   = '0;
          state_next = ST_SUB;
        end
      end
      ST_SUB: begin
        data_next = data_sub;
        // Counter parks on the last group instead of wrapping.
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign data_out = data_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: doc/aes_sbox_seq.md
AES_SBOX_SEQ -- requirements
Module: aes_sbox_seq

Interface
REQ-001 SHALL have parameter SBOX_LANES, default 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have parameter INV_EN, default 1, meaning 1 = inverse S-box datapath present, 0 = forward only.
REQ-003 sys_clk  input  1  single clock; all state updates on rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  data_in and inv_mode are valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 inv_mode  input  1  0 = forward SubBytes, 1 = InvSubBytes; sampled at accept.
REQ-008 data_in  input  128  state word to substitute.
REQ-009 out_valid  output  1  data_out holds a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 data_out  output  128  substituted state word.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SUB and DONE.
REQ-014 SHALL derive PASSES = 16/SBOX_LANES and a pass counter of width max(1,$clog2(PASSES)).
REQ-015 IDLE SHALL behave as follows: in_ready=1; on in_valid, capture data_in to the state register and inv_mode to a mode register, clear the counter, and go to SUB.
REQ-016 SUB SHALL, each cycle, replace byte group cnt (bits [cnt*8*SBOX_LANES +: 8*SBOX_LANES], LSB group first) with its substitution and increment cnt.
REQ-017 SUB SHALL go to DONE on the cycle it processes group PASSES-1; the counter SHALL NOT wrap past PASSES-1.
REQ-018 Latency from the accept edge to the first out_valid=1 cycle SHALL be exactly PASSES cycles (16 at SBOX_LANES=1, 1 at 16).
REQ-019 DONE SHALL assert out_valid=1 with data_out stable until out_ready=1, then go to IDLE.
REQ-020 in_ready SHALL be 0 in SUB and DONE; no overlap, so throughput is one word per PASSES+2 cycles minimum.
REQ-021 data_out SHALL equal the state register; its value outside DONE is don't-care but SHALL NOT be X after reset.
REQ-022 With INV_EN=0, inv_mode SHALL be ignored and forward substitution SHALL always be used.
REQ-023 A change to inv_mode or data_in after accept SHALL have no effect on the word in flight.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 sys_rst_n low SHALL immediately force: state IDLE, counter 0, state register 0, mode 0, out_valid 0, busy 0, in_ready 1 after release.
REQ-026 Reset asserted mid-SUB or mid-DONE SHALL discard the word in flight with no out_valid pulse.
REQ-027 The first accept SHALL be possible on the first rising edge with sys_rst_n high.

Structure
REQ-028 Shared package aes_pkg SHALL hold the 256-entry forward and inverse S-box constant tables and the FSM state enum.
REQ-029 SHALL instantiate SBOX_LANES copies of sub-module aes_sbox_lane (8-bit in, 8-bit out, inv select, purely combinational, forward/inverse table lookup).
REQ-030 Only one SBOX_LANES-wide group mux and one write-back path SHALL exist; no 16-lane datapath SHALL be built when SBOX_LANES<16.

Verification
REQ-031 SBOX_LANES=4, data_in=128'h0, inv_mode=0 -> out_valid exactly 4 cycles after accept, data_out=128'h6363...63.
REQ-032 SBOX_LANES=1, data_in bytes 00..0F, inv_mode=0 -> 16-cycle latency, data_out bytes 63,7C,77,7B,F2,6B,6F,C5,30,01,67,2B,FE,D7,AB,76.
REQ-033 inv_mode=1, data_in=128'h6363...63 -> data_out=128'h0; with INV_EN=0 the same stimulus yields 128'hFBFB...FB.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_valid and data_out stable, in_ready=0, then single handshake followed by return to IDLE.
REQ-035 sys_rst_n pulsed low during SUB (pass 2 of 4) -> out_valid never rises for that word; next word processed correctly.
REQ-036 SBOX_LANES=16, back-to-back in_valid with out_ready=1 -> one result every 3 cycles, bytes S(53)=ED, S(FF)=16 checked.
